// File: rtl/riscv_sched_pkg.sv
// Shared scheduler types and constants for dispatch/issue and the FU issue scheduler.
package riscv_sched_pkg;
    localparam logic FU_ALU      = 1'b0;
    localparam logic FU_MEM      = 1'b1;
    localparam int   NUM_ALU_FUS = 2;
    localparam int   NUM_MEM_FUS = 1;

    typedef enum logic {FU_TYPE_ALU = 1'b0, FU_TYPE_MEM = 1'b1} fu_type_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_fsm_t;
endpackage

// File: rtl/fu_issue_scheduler_rr_pick.sv
// Rotating find-first-set: first set bit of req at or above ptr, wrapping mod N.
module rr_pick #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         hit,
    output logic [W-1:0] idx
);
    logic [W-1:0] cand;

    // Walk offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + W'(i);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/fu_issue_scheduler.sv
// Issues up to two ALU ops and one MEM op per cycle from the RS array, round-robin per class.
// Optional FU_ISSUE_STATS_EN adds saturating issue/stall counters.
module fu_issue_scheduler
    import riscv_sched_pkg::*;
#(
    parameter  int NUM_RS_ROWS = 16,
    localparam int ROW_W       = $clog2(NUM_RS_ROWS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_RS_ROWS-1:0] rs_use_i,
    input  logic [NUM_RS_ROWS-1:0] rs_ready_i,
    input  logic [NUM_RS_ROWS-1:0] rs_fu_type_i,
    input  logic                   alu_stall_i,
    input  logic                   mem_done_i,
    output logic                   alu0_issue_o,
    output logic [ROW_W-1:0]       alu0_row_o,
    output logic                   alu1_issue_o,
    output logic [ROW_W-1:0]       alu1_row_o,
    output logic                   mem_issue_o,
    output logic [ROW_W-1:0]       mem_row_o,
    output logic [NUM_RS_ROWS-1:0] rs_clear_o,
    output logic                   mem_busy_o
`ifdef FU_ISSUE_STATS_EN
    ,
    output logic [31:0]            stat_alu_issued_o,
    output logic [31:0]            stat_mem_issued_o,
    output logic [31:0]            stat_stall_cycles_o
`endif
);
    localparam int N = NUM_RS_ROWS;

    logic [N-1:0]     elig, alu_req, alu_req1, mem_req, clear_next;
    logic             alu_hit0, alu_hit1, mem_hit;
    logic [ROW_W-1:0] alu_idx0, alu_idx1, mem_idx;
    logic [ROW_W-1:0] alu_ptr, mem_ptr;
    logic             alu_go0, alu_go1, mem_go;
    mem_fsm_t         mem_state;

    // Rows granted last cycle are still visible in the RS until the coming edge.
    assign elig     = rs_use_i & rs_ready_i & ~rs_clear_o;
    assign alu_req  = elig & ~rs_fu_type_i;
    assign mem_req  = elig & rs_fu_type_i;
    assign alu_req1 = alu_req & ~(N'(1) << alu_idx0);

    rr_pick #(.N(N)) u_pick_alu0 (.req(alu_req),  .ptr(alu_ptr), .hit(alu_hit0), .idx(alu_idx0));
    rr_pick #(.N(N)) u_pick_alu1 (.req(alu_req1), .ptr(alu_ptr), .hit(alu_hit1), .idx(alu_idx1));
    rr_pick #(.N(N)) u_pick_mem  (.req(mem_req),  .ptr(mem_ptr), .hit(mem_hit),  .idx(mem_idx));

    assign alu_go0 = alu_hit0 & ~alu_stall_i;
    assign alu_go1 = alu_hit1 & ~alu_stall_i;
    assign mem_go  = mem_hit & (mem_state == IDLE);

    always_comb begin
        clear_next = '0;
        if (alu_go0) clear_next[alu_idx0] = 1'b1;
        if (alu_go1) clear_next[alu_idx1] = 1'b1;
        if (mem_go)  clear_next[mem_idx]  = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu0_issue_o <= 1'b0;
            alu0_row_o   <= '0;
            alu1_issue_o <= 1'b0;
            alu1_row_o   <= '0;
            mem_issue_o  <= 1'b0;
            mem_row_o    <= '0;
            rs_clear_o   <= '0;
            alu_ptr      <= '0;
            mem_ptr      <= '0;
            mem_state    <= IDLE;
        end else begin
            alu0_issue_o <= alu_go0;
            alu0_row_o   <= alu_go0 ? alu_idx0 : '0;
            alu1_issue_o <= alu_go1;
            alu1_row_o   <= alu_go1 ? alu_idx1 : '0;
            mem_issue_o  <= mem_go;
            mem_row_o    <= mem_go ? mem_idx : '0;
            rs_clear_o   <= clear_next;
            if (alu_go1)      alu_ptr <= alu_idx1 + ROW_W'(1);
            else if (alu_go0) alu_ptr <= alu_idx0 + ROW_W'(1);
            case (mem_state)
                IDLE: if (mem_go) begin
                    mem_state <= BUSY;
                    mem_ptr   <= mem_idx + ROW_W'(1);
                end
                BUSY: if (mem_done_i) mem_state <= IDLE;
                default: mem_state <= IDLE;
            endcase
        end
    end

    assign mem_busy_o = (mem_state == BUSY);

`ifdef FU_ISSUE_STATS_EN
    logic [32:0] alu_sum, mem_sum, stall_sum;

    assign alu_sum   = {1'b0, stat_alu_issued_o} + 33'(alu_go0) + 33'(alu_go1);
    assign mem_sum   = {1'b0, stat_mem_issued_o} + 33'(mem_go);
    assign stall_sum = {1'b0, stat_stall_cycles_o} + 33'((|elig) & ~(alu_go0 | mem_go));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_alu_issued_o   <= '0;
            stat_mem_issued_o   <= '0;
            stat_stall_cycles_o <= '0;
        end else begin
            stat_alu_issued_o   <= alu_sum[32]   ? '1 : alu_sum[31:0];
            stat_mem_issued_o   <= mem_sum[32]   ? '1 : mem_sum[31:0];
            stat_stall_cycles_o <= stall_sum[32] ? '1 : stall_sum[31:0];
        end
    end
`endif
endmodule
